n_bit_adder: RTL and testbench
==============================

N_BIT_ADDER -- requirements
Module: n_bit_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and sum width in bits; legal values are 1..64.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have input a, WIDTH bits: operand A, unsigned, also interpreted as two's complement for overflow.
REQ-005 The block SHALL have input b, WIDTH bits: operand B, same interpretation as a.
REQ-006 The block SHALL have input cin, 1 bit: carry into bit 0.
REQ-007 The block SHALL have input in_valid, 1 bit: a, b and cin are sampled this cycle.
REQ-008 The block SHALL have output sum, WIDTH bits: registered (a + b + cin) mod 2^WIDTH.
REQ-009 The block SHALL have output cout, 1 bit: registered carry out of bit WIDTH-1.
REQ-010 The block SHALL have output overflow, 1 bit: registered signed overflow, computed as carry into MSB XOR carry out of MSB.
REQ-011 The block SHALL have output out_valid, 1 bit: sum, cout and overflow hold a new result.

Function
REQ-012 The adder core SHALL be a ripple-carry chain of WIDTH one-bit full-adder cells.
- Each cell: s = a ^ b ^ c; co = (a & b) | (c & (a ^ b)).
- Carry into cell 0 is cin; carry into cell i+1 is co of cell i.
REQ-013 cout SHALL be co of cell WIDTH-1, so {cout, sum} = a + b + cin exactly, for a result range 0..2^(WIDTH+1)-1.
REQ-014 Latency SHALL be 1 cycle: when in_valid=1 at rising edge N, sum/cout/overflow reflect that operand set from edge N until the next accepted set.
REQ-015 out_valid SHALL be in_valid registered, i.e. 1 for exactly the cycle after each accepted input.
REQ-016 When in_valid=0, sum/cout/overflow SHALL hold their previous values.
REQ-017 Back-to-back in_valid=1 SHALL be accepted every cycle, giving one result per cycle with no bubbles.
REQ-018 There SHALL be no handshake backpressure; the block is always ready.
REQ-019 WIDTH=1 SHALL degenerate to a single registered full adder, with overflow = cin XOR cout.
REQ-020 Wrap-around SHALL follow these cases:
- All-ones + 0 + cin=1 gives sum=0, cout=1.
- All-ones + all-ones + 1 gives sum all-ones, cout=1.

Reset
REQ-021 While rst=1, sum, cout, overflow and out_valid SHALL be 0 immediately, independent of clk.
REQ-022 An input presented in the same cycle rst deasserts SHALL be accepted on the first rising edge where rst=0.
REQ-023 Reset asserted mid-stream SHALL discard any pending result; out_valid SHALL be 0 on the first edge after release unless in_valid=1 on that edge.

Verification (WIDTH=4)
REQ-024 The bench SHALL cover these directed scenarios:
- a=0000, b=0000, cin=0, in_valid=1 -> next cycle sum=0000, cout=0, overflow=0, out_valid=1.
- a=0011, b=1010, cin=1 -> sum=1110, cout=0, overflow=0.
- a=1001, b=0110, cin=1 -> sum=0000, cout=1, overflow=0.
- a=1111, b=0000, cin=0 -> sum=1111, cout=0; then a=1010, b=1100, cin=1 -> sum=0111, cout=1, overflow=1.
- a=0111, b=0001, cin=0 -> sum=1000, cout=0, overflow=1; then in_valid=0 for 3 cycles -> outputs hold, out_valid=0.
- Reset case: assert rst asynchronously between edges -> all outputs 0 before the next edge; release rst -> outputs stay 0 until a valid input arrives.
REQ-025 The bench SHALL run an exhaustive check at WIDTH=4 over all a, b and cin, comparing {cout, sum} to a+b+cin and overflow to the signed-range check, one cycle after each input.

Source files
------------

// File: rtl/n_bit_adder.sv
// Registered ripple-carry adder with carry-out and signed overflow.
// One result per accepted input, one cycle of latency.
module n_bit_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_valid;

  assign w_c[0] = cin;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
    assign w_s[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i])
                    | (w_c[i] & (a[i] ^ b[i]));
  end

  // Carry into the MSB cell differs from carry out of it.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  // Capture a result on each accepted input; hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_s;
        r_cout <= w_c[WIDTH];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_n_bit_adder.sv
// Bench for n_bit_adder at WIDTH=4: directed, reset,
// random and exhaustive checks against an arithmetic model.
module tb_n_bit_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         out_valid;

  int n_tests;
  int n_fail;

  // Last expected {sum, cout, overflow}
  logic [W+1:0] exp_q;
  logic [W+2:0] got;
  logic [W+2:0] exp;

  n_bit_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .in_valid (in_valid),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign got = {sum, cout, overflow, out_valid};

  // {sum, cout, overflow} from plain integer arithmetic
  function automatic logic [W+1:0] model(
    input logic [W-1:0] ta,
    input logic [W-1:0] tb,
    input logic         tc
  );
    int u;
    int sa;
    int sb;
    int ss;
    logic ov;
    logic [W:0] uv;
    u  = int'(ta) + int'(tb) + int'(tc);
    sa = ta[W-1] ? int'(ta) - (1 << W) : int'(ta);
    sb = tb[W-1] ? int'(tb) - (1 << W) : int'(tb);
    ss = sa + sb + int'(tc);
    ov = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
    uv = u[W:0];
    return {uv[W-1:0], uv[W], ov};
  endfunction

  task automatic drive(
    input logic [W-1:0] ta,
    input logic [W-1:0] tb,
    input logic         tc,
    input logic         tv
  );
    a        = ta;
    b        = tb;
    cin      = tc;
    in_valid = tv;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_initial: got %b expected %b", got, 7'b0);
    end
    for (int i = 0; i < 2; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      step();
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL reset_held: got %b expected %b", got, 7'b0);
      end
    end
    // Input presented in the cycle reset drops is accepted
    rst = 1'b0;
    drive(4'd5, 4'd6, 1'b1, 1'b1);
    step();
    exp_q = model(4'd5, 4'd6, 1'b1);
    exp   = {exp_q, 1'b1};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_release_accept: got %b expected %b", got, exp);
    end
  endtask

  task automatic test_directed;
    // {a, b, cin, sum, cout, overflow}
    logic [14:0] tbl [8];
    tbl[0] = {4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = {4'b0011, 4'b1010, 1'b1, 4'b1110, 1'b0, 1'b0};
    tbl[2] = {4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[3] = {4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0};
    tbl[4] = {4'b1010, 4'b1100, 1'b1, 4'b0111, 1'b1, 1'b1};
    tbl[5] = {4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[6] = {4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[7] = {4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i][14:11], tbl[i][10:7], tbl[i][6], 1'b1);
      step();
      exp_q = tbl[i][5:0];
      exp   = {exp_q, 1'b1};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL directed_%0d: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 3; i++) begin
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      step();
      exp = {exp_q, 1'b0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL hold_%0d: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(4'd9, 4'd9, 1'b0, 1'b1);
    step();
    exp_q = model(4'd9, 4'd9, 1'b0);
    exp   = {exp_q, 1'b1};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL pre_reset: got %b expected %b", got, exp);
    end
    // Pending input must be discarded by a mid-cycle reset
    drive(4'd7, 4'd3, 1'b1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", got, 7'b0);
    end
    step();
    rst = 1'b0;
    drive(4'd7, 4'd3, 1'b1, 1'b0);
    exp_q = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (got !== '0) begin
        n_fail++;
        $display("FAIL post_reset_idle_%0d: got %b expected %b", i, got, 7'b0);
      end
    end
    drive(4'd8, 4'd8, 1'b0, 1'b1);
    step();
    exp_q = model(4'd8, 4'd8, 1'b0);
    exp   = {exp_q, 1'b1};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL post_reset_first: got %b expected %b", got, exp);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rv;
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      rv = ($urandom_range(3, 0) != 0);
      drive(ra, rb, rc, rv);
      step();
      if (rv) begin
        exp_q = model(ra, rb, rc);
      end
      exp = {exp_q, rv};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h b=%h cin=%b got %b expected %b",
                 i, ra, rb, rc, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         ec;
    int           u;
    for (int i = 0; i < 512; i++) begin
      ea = 4'(i >> 5);
      eb = 4'(i >> 1);
      ec = 1'(i);
      drive(ea, eb, ec, 1'b1);
      step();
      exp_q = model(ea, eb, ec);
      exp   = {exp_q, 1'b1};
      u     = int'(ea) + int'(eb) + int'(ec);
      n_tests++;
      if (got !== exp || int'({cout, sum}) != u) begin
        n_fail++;
        $display("FAIL exhaustive: a=%h b=%h cin=%b got %b expected %b",
                 ea, eb, ec, got, exp);
      end
    end
    drive('0, '0, 1'b0, 1'b0);
    step();
    exp = {exp_q, 1'b0};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL stream_end: got %b expected %b", got, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_q   = '0;
    test_reset();
    test_directed();
    test_hold();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
